// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle RV32I sequencer owning the PC, fetch/data handshakes, retire count and traps
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    input  logic [31:0] dnpc,
    input  logic        is_mem,
    input  logic        halt,
    output logic        dmem_req,
    input  logic        dmem_ready,
    output logic        wb_en,
    output logic        retire,
    output logic [31:0] instret,
    output logic [2:0]  state,
    output logic [1:0]  cause
);
    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4,
        TRAP  = 3'd5
    } state_t;
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   instret_q, instret_d;
    logic [1:0]    cause_q, cause_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready;
    logic          expired;
    logic          commit;
    assign ready   = (state_q == FETCH) ? imem_ready : dmem_ready;
    assign expired = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign commit  = (state_q == WB) && (dnpc[1:0] == 2'b00);
    // Counter is zero on every entry to FETCH/MEM because all other states drive it to zero.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        cause_d   = cause_q;
        cnt_d     = '0;
        case (state_q)
            FETCH, MEM: begin
                if (ready) begin
                    state_d = (state_q == FETCH) ? EXEC : WB;
                    instr_d = (state_q == FETCH) ? imem_rdata : instr_q;
                end else if (expired) begin
                    state_d = TRAP;
                    cause_d = (state_q == FETCH) ? 2'd2 : 2'd3;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end
            EXEC: state_d = halt ? HALT : (is_mem ? MEM : WB);
            WB: begin
                state_d   = commit ? FETCH : TRAP;
                cause_d   = commit ? cause_q : 2'd1;
                pc_d      = commit ? dnpc : pc_q;
                instret_d = commit ? instret_q + 32'd1 : instret_q;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            instret_q <= '0;
            cause_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
            cause_q   <= cause_d;
            cnt_q     <= cnt_d;
        end
    end
    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign dmem_req  = (state_q == MEM);
    assign wb_en     = commit;
    assign retire    = commit;
    assign instr     = instr_q;
    assign pc        = pc_q;
    assign instret   = instret_q;
    assign state     = state_q;
    assign cause     = cause_q;
endmodule
